midi_uart_rx: RTL

MIDI_UART_RX -- requirements
Module: midi_uart_rx

---
 rtl/midi_pkg.sv | 27 ++
 rtl/midi_baud_gen.sv | 39 +++
 rtl/midi_uart_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI UART receiver.
// Contents: FSM state encoding, default oversampling ratio and MIDI baud,
// the tick indices within a bit where the line is sampled, and a 3-input
// majority helper.
package midi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } midi_state_e;

  localparam int unsigned MidiBaud   = 31250;
  localparam int unsigned DefaultOvs = 16;

  // Ticks within a bit (counted 1..OVS from the bit start) where rx is sampled.
  localparam int unsigned SampleEarly = 7;
  localparam int unsigned SampleMid   = 8;
  localparam int unsigned SampleLate  = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/midi_baud_gen.sv
// Oversampling tick divider for the MIDI receiver.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   resync - restart the divide count so the next tick lands DIV clocks later
//   tick   - one-cycle pulse every DIV clocks
module midi_baud_gen #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic resync,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));
  assign tick = wrap;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (resync || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1 frames, 16x oversampled, 3-sample majority vote.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-low reset
//   rx          - asynchronous serial line, idles high
//   valid_byte  - one-cycle pulse when data holds a newly received good byte
//   data        - last correctly framed byte, held until the next one
//   framing_err - one-cycle pulse when the stop bit is sampled low
//   busy        - high from confirmed start bit until the frame's pulse
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = MidiBaud,
  parameter int unsigned OVS    = DefaultOvs
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       valid_byte,
  output logic [7:0] data,
  output logic       framing_err,
  output logic       busy
);

  localparam int unsigned Div = CLK_HZ / (BAUD * OVS);
  localparam int unsigned TW  = $clog2(OVS + 1);

  midi_state_e state_q, state_d;

  logic          sync1_q, sync2_q, rx_sync;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [2:0]    bcnt_q, bcnt_d;
  logic          s_early_q, s_early_d, s_mid_q, s_mid_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d, busy_q, busy_d;
  logic [1:0]    settle_q, settle_d;
  logic          tick, resync, at_mid, at_late, bit_val, stop_done, stop_bit;

  assign rx_sync = sync2_q;

  midi_baud_gen #(
    .DIV(Div)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .resync(resync),
    .tick  (tick)
  );

  assign tcnt_inc = tcnt_q + 1'b1;
  assign at_mid   = tick && (tcnt_inc == TW'(SampleMid));
  assign at_late  = tick && (tcnt_inc == TW'(SampleLate));
  assign bit_val  = maj3(s_early_q, s_mid_q, rx_sync);
  // Two agreeing samples already decide the vote, so the stop bit can resolve
  // at the mid-bit tick and free the FSM early for a back-to-back start edge.
  assign stop_done = (at_mid && (s_early_q == rx_sync)) || at_late;
  assign stop_bit  = at_mid ? rx_sync : bit_val;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    s_early_d = s_early_q;
    s_mid_d   = s_mid_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;
    resync    = 1'b0;
    // Counts cycles since reset release until the synchroniser holds real rx.
    settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

    if (tick && (state_q != StIdle) && (state_q != StWaitHigh)) begin
      tcnt_d = (tcnt_inc == TW'(OVS)) ? '0 : tcnt_inc;
      if (tcnt_inc == TW'(SampleEarly)) s_early_d = rx_sync;
      if (tcnt_inc == TW'(SampleMid))   s_mid_d   = rx_sync;
    end

    unique case (state_q)
      StIdle: begin
        // IDLE is only ever entered with the line high, so a low level here is
        // the falling edge. The first valid synchronised sample after reset
        // being low means the line was already low at release.
        if (!rx_sync && (settle_q >= 2'd2)) begin
          if (settle_q == 2'd2) begin
            state_d = StWaitHigh;
          end else begin
            state_d = StStart;
            tcnt_d  = '0;
            resync  = 1'b1;
          end
        end
      end
      StStart: begin
        if (at_late) begin
          if (!bit_val) begin
            state_d = StData;
            busy_d  = 1'b1;
            bcnt_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (at_late) begin
          shift_d = {bit_val, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (stop_done) begin
          busy_d = 1'b0;
          if (stop_bit) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rx_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      s_early_q <= 1'b1;
      s_mid_q   <= 1'b1;
      shift_q   <= 8'hFF;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      s_early_q <= s_early_d;
      s_mid_q   <= s_mid_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      settle_q  <= settle_d;
    end
  end

  assign valid_byte  = valid_q;
  assign framing_err = ferr_q;
  assign busy        = busy_q;
  assign data        = data_q;

endmodule
